// File: rtl/mprj_pad_cfg_loader.sv
// Serial configuration loader for user-project pads: holds an N x B image and shifts it
// into the padframe control chain, then strobes load. Readback port under MPRJ_PAD_CFG_READBACK_EN.
module mprj_pad_cfg_loader #(
    parameter int                  NUM_PADS    = 38,
    parameter int                  CFG_BITS    = 13,
    parameter int                  CLK_DIV     = 2,
    parameter logic [CFG_BITS-1:0] CFG_DEFAULT = 13'h0403,
    localparam int                 AW          = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [CFG_BITS-1:0] wr_data,
    input  logic                start,
    input  logic                err_clr,
`ifdef MPRJ_PAD_CFG_READBACK_EN
    input  logic [AW-1:0]       rd_addr,
    output logic [CFG_BITS-1:0] rd_data,
`endif
    output logic                busy,
    output logic                done,
    output logic                wr_err,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load
);

    localparam int TOTAL = NUM_PADS * CFG_BITS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int PW    = $clog2(CLK_DIV + 1);
    localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CW-1:0] BIT_FIRST = CW'(TOTAL - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
    localparam logic [AW:0]   PAD_LIMIT = (AW + 1)'(NUM_PADS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LOAD     = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       bit_cnt_r;
    logic [PW-1:0]       phase_r;
    logic [CFG_BITS-1:0] image_r      [NUM_PADS];
    logic [CFG_BITS-1:0] image_next_s [NUM_PADS];
    logic [TOTAL-1:0]    flat_s;
    logic [IW-1:0]       sel_s;
    logic                wr_ok_s;
    logic                wr_rej_s;
    logic                next_bit_s;

    // Classify the current write strobe as accepted or rejected
    always_comb begin
        wr_ok_s  = 1'b0;
        wr_rej_s = 1'b0;
        if (wr_en) begin
            if ((state_r == IDLE) && ({1'b0, wr_addr} < PAD_LIMIT)) begin
                wr_ok_s = 1'b1;
            end else begin
                wr_rej_s = 1'b1;
            end
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Image with this cycle's write merged in, so a write coinciding with start is shifted
    always_comb begin
        flat_s = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            image_next_s[p] = (wr_ok_s && (wr_addr == AW'(p))) ? wr_data : image_r[p];
            for (int b = 0; b < CFG_BITS; b++) begin
                flat_s[p*CFG_BITS + b] = image_next_s[p][b];
            end
        end
    end

    // Index of the bit that goes onto serial_data at the next SHIFT_LO entry
    always_comb begin
        if (state_r == IDLE) begin
            sel_s = IW'(TOTAL - 1);
        end else begin
            sel_s = IW'(bit_cnt_r - CW'(1));
        end
        next_bit_s = flat_s[sel_s];
    end

    // Configuration image storage; frozen during a load because writes are rejected then
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PADS; p++) begin
            if (!resetb) begin
                image_r[p] <= CFG_DEFAULT;
            end else begin
                image_r[p] <= image_next_s[p];
            end
        end
    end

    // Sticky write-error flag; a rejecting write beats a simultaneous clear
    always_ff @(posedge clock) begin
        if (!resetb) begin
            wr_err <= 1'b0;
        end else if (wr_rej_s) begin
            wr_err <= 1'b1;
        end else if (err_clr) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_err;
        end
    end

    // Load sequencer with registered chain outputs
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_r      <= IDLE;
            bit_cnt_r    <= '0;
            phase_r      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r      <= SHIFT_LO;
                        bit_cnt_r    <= BIT_FIRST;
                        phase_r      <= '0;
                        busy         <= 1'b1;
                        serial_clock <= 1'b0;
                        serial_data  <= next_bit_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT_LO: begin
                    if (phase_r == PH_LAST) begin
                        state_r      <= SHIFT_HI;
                        phase_r      <= '0;
                        serial_clock <= 1'b1;
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (phase_r == PH_LAST) begin
                        phase_r      <= '0;
                        serial_clock <= 1'b0;
                        if (bit_cnt_r == '0) begin
                            state_r     <= LOAD;
                            serial_data <= 1'b0;
                            serial_load <= 1'b1;
                        end else begin
                            state_r     <= SHIFT_LO;
                            bit_cnt_r   <= bit_cnt_r - CW'(1);
                            serial_data <= next_bit_s;
                        end
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                LOAD: begin
                    if (phase_r == PH_LAST) begin
                        state_r     <= DONE;
                        phase_r     <= '0;
                        serial_load <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        phase_r <= phase_r + PW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    serial_clock <= 1'b0;
                    serial_data  <= 1'b0;
                    serial_load  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MPRJ_PAD_CFG_READBACK_EN
    logic [CFG_BITS-1:0] rd_sel_s;

    // Select the addressed word; out-of-range addresses read as zero
    always_comb begin
        rd_sel_s = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (rd_addr == AW'(p)) begin
                rd_sel_s = image_r[p];
            end else begin
                rd_sel_s = rd_sel_s;
            end
        end
    end

    // Registered readback port
    always_ff @(posedge clock) begin
        if (!resetb) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_sel_s;
        end
    end
`endif

endmodule

// File: tb/tb_mprj_pad_cfg_loader.sv
// Self-checking bench for mprj_pad_cfg_loader: two instances (4 pads / CLK_DIV=2 and
// 5 pads / CLK_DIV=1) checked against a pad-image model and the serial-order rule.
module tb_mprj_pad_cfg_loader;

    logic        clock = 1'b0;
    logic        resetb, wr_en, start, err_clr, sel;
    logic [2:0]  wr_addr;
    logic [12:0] wr_data;
    logic        busy_a, done_a, err_a, sc_a, sd_a, ld_a;
    logic        busy_b, done_b, err_b, sc_b, sd_b, ld_b;
    logic        o_busy, o_done, o_err, o_sc, o_sd, o_ld;
`ifdef MPRJ_PAD_CFG_READBACK_EN
    logic [2:0]  rd_addr;
    logic [12:0] rd_data_a, rd_data_b;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [12:0] mdl     [2][8];
    logic        mdl_err [2];

    always #5 clock = ~clock;

    mprj_pad_cfg_loader #(.NUM_PADS(4), .CFG_BITS(13), .CLK_DIV(2), .CFG_DEFAULT(13'h0403)) dut_a (
        .clock(clock), .resetb(resetb), .wr_en(wr_en & ~sel), .wr_addr(wr_addr[1:0]),
        .wr_data(wr_data), .start(start & ~sel), .err_clr(err_clr & ~sel),
`ifdef MPRJ_PAD_CFG_READBACK_EN
        .rd_addr(rd_addr[1:0]), .rd_data(rd_data_a),
`endif
        .busy(busy_a), .done(done_a), .wr_err(err_a),
        .serial_clock(sc_a), .serial_data(sd_a), .serial_load(ld_a));

    mprj_pad_cfg_loader #(.NUM_PADS(5), .CFG_BITS(13), .CLK_DIV(1), .CFG_DEFAULT(13'h0403)) dut_b (
        .clock(clock), .resetb(resetb), .wr_en(wr_en & sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start & sel), .err_clr(err_clr & sel),
`ifdef MPRJ_PAD_CFG_READBACK_EN
        .rd_addr(rd_addr), .rd_data(rd_data_b),
`endif
        .busy(busy_b), .done(done_b), .wr_err(err_b),
        .serial_clock(sc_b), .serial_data(sd_b), .serial_load(ld_b));

    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_err  = sel ? err_b  : err_a;
    assign o_sc   = sel ? sc_b   : sc_a;
    assign o_sd   = sel ? sd_b   : sd_a;
    assign o_ld   = sel ? ld_b   : ld_a;

    function automatic int np_of(input logic s);
        return s ? 5 : 4;
    endfunction

    function automatic int div_of(input logic s);
        return s ? 1 : 2;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mdl_err[s] = 1'b0;
            for (int p = 0; p < 8; p++) mdl[s][p] = 13'h0403;
        end
    endtask

    task automatic apply_reset();
        resetb = 1'b0;
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        model_reset();
    endtask

    // Idle-time write; the model accepts it only for an existing pad
    task automatic wr(input logic [2:0] a, input logic [12:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        @(negedge clock);
        wr_en = 1'b0;
        if (int'(a) < np_of(sel)) mdl[sel][a] = v;
        else mdl_err[sel] = 1'b1;
    endtask

    // Start a load and watch it to completion; optional same-cycle write, mid-load write and restart
    task automatic run_load(input string tag, input bit same_wr, input logic [2:0] sw_a,
                            input logic [12:0] sw_d, input int mid_at, input logic [2:0] mid_a,
                            input logic [12:0] mid_d, input int restart_at);
        int   np = np_of(sel);
        int   d  = div_of(sel);
        int   len = 2 * d * np * 13 + d;
        int   done_cyc = -1, done_n = 0, busy_bad = 0, load_bad = 0, glitch = 0, bit_bad = -1;
        logic prev_sc = 1'b0, prev_sd = 1'b0;
        logic exp_q[$];
        logic got_q[$];
        start = 1'b1;
        if (same_wr) begin
            wr_en = 1'b1; wr_addr = sw_a; wr_data = sw_d;
            mdl[sel][sw_a] = sw_d;
        end
        for (int p = np - 1; p >= 0; p--)
            for (int b = 12; b >= 0; b--) exp_q.push_back(mdl[sel][p][b]);
        @(negedge clock);
        start = 1'b0; wr_en = 1'b0;
        for (int cyc = 0; cyc < len + 6; cyc++) begin
            if (o_busy !== (cyc < len)) busy_bad++;
            if (o_ld !== ((cyc >= len - d) && (cyc < len))) load_bad++;
            if (o_done === 1'b1) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (o_sc === 1'b1 && prev_sc === 1'b0) got_q.push_back(o_sd);
            if (o_sd !== prev_sd && o_sc !== 1'b0) glitch++;
            prev_sc = o_sc; prev_sd = o_sd;
            wr_en = (cyc == mid_at);
            if (cyc == mid_at) begin
                wr_addr = mid_a; wr_data = mid_d; mdl_err[sel] = 1'b1;
            end
            start = (cyc == restart_at);
            @(negedge clock);
        end
        wr_en = 1'b0; start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++)
            if (bit_bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bit_bad = i;
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL %s busy_window bad_cycles=%0d required=0", tag, busy_bad); end
        checks++; if (done_cyc != len) begin errors++; $display("FAIL %s done_cycle got=%0d required=%0d", tag, done_cyc, len); end
        checks++; if (done_n != 1) begin errors++; $display("FAIL %s done_pulses got=%0d required=1", tag, done_n); end
        checks++; if (load_bad != 0) begin errors++; $display("FAIL %s load_window bad_cycles=%0d required=0", tag, load_bad); end
        checks++; if (glitch != 0) begin errors++; $display("FAIL %s data_change_while_sclk_high got=%0d required=0", tag, glitch); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL %s bit_count got=%0d required=%0d", tag, got_q.size(), exp_q.size()); end
        checks++; if (bit_bad >= 0) begin errors++; $display("FAIL %s bit_stream first_bad_index=%0d required=none", tag, bit_bad); end
        checks++; if (o_err !== mdl_err[sel]) begin errors++; $display("FAIL %s wr_err got=%b required=%b", tag, o_err, mdl_err[sel]); end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({busy_a, done_a, err_a, sc_a, sd_a, ld_a} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs_a got=%b required=000000", {busy_a, done_a, err_a, sc_a, sd_a, ld_a});
        end
        checks++;
        if ({busy_b, done_b, err_b, sc_b, sd_b, ld_b} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs_b got=%b required=000000", {busy_b, done_b, err_b, sc_b, sd_b, ld_b});
        end
        sel = 1'b0;
        run_load("reset_default_a", 1'b0, 3'd0, 13'h0, -1, 3'd0, 13'h0, -1);
    endtask

    task automatic test_order();
        sel = 1'b0;
        wr(3'd3, 13'h1FFF);
        wr(3'd0, 13'h0001);
        run_load("order_a", 1'b0, 3'd0, 13'h0, -1, 3'd0, 13'h0, -1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            sel = 1'($urandom_range(0, 1));
            @(negedge clock);
            for (int k = 0; k < 4; k++)
                wr(3'($urandom_range(0, np_of(sel) - 1)), 13'($urandom));
            run_load("random", 1'b0, 3'd0, 13'h0, -1, 3'd0, 13'h0, -1);
        end
    endtask

    task automatic test_busy_write();
        sel = 1'b0;
        @(negedge clock);
        run_load("busy_write", 1'b0, 3'd0, 13'h0, 20, 3'd1, 13'($urandom), -1);
        run_load("busy_write_reload", 1'b0, 3'd0, 13'h0, -1, 3'd0, 13'h0, -1);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0; mdl_err[0] = 1'b0;
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL err_clr got=%b required=0", o_err); end
    endtask

    task automatic test_out_of_range();
        sel = 1'b1;
        @(negedge clock);
        wr(3'd4, 13'($urandom));
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL last_pad_write_err got=%b required=0", o_err); end
        wr(3'd5, 13'h1234);
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL oor_write_err got=%b required=1", o_err); end
        err_clr = 1'b1;
        wr(3'd6, 13'h0555);
        err_clr = 1'b0;
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL set_beats_clear got=%b required=1", o_err); end
        run_load("oor_restart_b", 1'b0, 3'd0, 13'h0, -1, 3'd0, 13'h0, 30);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0; mdl_err[1] = 1'b0;
    endtask

    task automatic test_same_cycle();
        sel = 1'b1;
        @(negedge clock);
        run_load("same_cycle_b", 1'b1, 3'd4, 13'($urandom), -1, 3'd0, 13'h0, -1);
        run_load("same_cycle_b0", 1'b1, 3'd0, 13'($urandom), -1, 3'd0, 13'h0, -1);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        sel = 1'b0;
        wr(3'd2, 13'h1555);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (49) @(negedge clock);
        resetb = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
        model_reset();
        checks++;
        if ({busy_a, done_a, err_a, sc_a, sd_a, ld_a} !== 6'b0) begin
            errors++; $display("FAIL mid_reset_outputs got=%b required=000000", {busy_a, done_a, err_a, sc_a, sd_a, ld_a});
        end
        for (int i = 0; i < 250; i++) begin
            if (ld_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) pulses++;
            @(negedge clock);
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL mid_reset_activity got=%0d required=0", pulses); end
        run_load("after_mid_reset", 1'b0, 3'd0, 13'h0, -1, 3'd0, 13'h0, -1);
    endtask

`ifdef MPRJ_PAD_CFG_READBACK_EN
    task automatic test_readback();
        sel = 1'b1;
        wr(3'd2, 13'h0ABC);
        rd_addr = 3'd2;
        @(negedge clock);
        checks++;
        if (rd_data_b !== 13'h0ABC) begin errors++; $display("FAIL readback got=%h required=0abc", rd_data_b); end
        rd_addr = 3'd7;
        @(negedge clock);
        checks++;
        if (rd_data_b !== 13'h0) begin errors++; $display("FAIL readback_oor got=%h required=0000", rd_data_b); end
    endtask
`endif

    initial begin
        resetb = 1'b0; wr_en = 1'b0; start = 1'b0; err_clr = 1'b0; sel = 1'b0;
        wr_addr = 3'd0; wr_data = 13'h0;
`ifdef MPRJ_PAD_CFG_READBACK_EN
        rd_addr = 3'd0;
`endif
        @(negedge clock);
        test_reset();
        test_order();
        test_random();
        test_busy_write();
        test_out_of_range();
        test_same_cycle();
        test_reset_mid();
`ifdef MPRJ_PAD_CFG_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
